// File: rtl/gfx_pkg.sv
// Shared graphics types: attribute-ID width, index triples, 3x32 vectors
// and the vertex-fetch walk states.
package gfx_pkg;
    localparam int ATTR_ID_W = 12;
    localparam int INDEX_W   = 16;
    localparam int COMP_W    = 32;

    localparam int POS_SEL = 0;
    localparam int NRM_SEL = 1;
    localparam int MAT_SEL = 2;

    typedef logic [ATTR_ID_W-1:0]       attr_id_t;
    typedef logic [INDEX_W-1:0]         index_t;
    typedef logic [2:0][COMP_W-1:0]     vec3_t;
    typedef logic [2:0][ATTR_ID_W-1:0]  idx3_t;

    typedef enum logic [1:0] {
        IDLE,
        IDX_WAIT,
        ATTR_WAIT,
        EMIT
    } vf_state_e;
endpackage

// File: rtl/vertex_fetch_if.sv
// Command, memory and vertex-stream signals of the vertex fetcher.
interface vertex_fetch_if;
    import gfx_pkg::*;

    logic     start_in;
    index_t   index_count_in;
    logic     busy_out;
    logic     done_out;

    index_t   index_id_out;
    idx3_t    index_in;
    attr_id_t position_id_out;
    attr_id_t normal_id_out;
    attr_id_t material_id_out;
    vec3_t    position_in;
    vec3_t    normal_in;
    vec3_t    material_in;

    logic     vertex_valid_out;
    logic     vertex_ready_in;
    vec3_t    vertex_position_out;
    vec3_t    vertex_normal_out;
    vec3_t    vertex_material_out;
    logic     tri_end_out;
    logic     last_out;

    modport slave (
        input  start_in, index_count_in, index_in, position_in, normal_in,
               material_in, vertex_ready_in,
        output busy_out, done_out, index_id_out, position_id_out, normal_id_out,
               material_id_out, vertex_valid_out, vertex_position_out,
               vertex_normal_out, vertex_material_out, tri_end_out, last_out
    );

    modport master (
        output start_in, index_count_in, index_in, position_in, normal_in,
               material_in, vertex_ready_in,
        input  busy_out, done_out, index_id_out, position_id_out, normal_id_out,
               material_id_out, vertex_valid_out, vertex_position_out,
               vertex_normal_out, vertex_material_out, tri_end_out, last_out
    );
endinterface

// File: rtl/vertex_fetch.sv
// Walks an index buffer, fetches position/normal/material per vertex and
// streams assembled vertices with triangle-end and last markers.
module vertex_fetch
    import gfx_pkg::*;
#(
    parameter int MEM_LATENCY = 2
) (
    input  logic          clk_in,
    input  logic          rst_in,
    vertex_fetch_if.slave vf
);
    localparam int WAIT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_LATENCY - 1);

    vf_state_e         state;
    vf_state_e         state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    index_t            vtx_cnt;
    index_t            count_r;
    logic [1:0]        tri_phase;
    attr_id_t          pos_id;
    attr_id_t          nrm_id;
    attr_id_t          mat_id;
    vec3_t             pos_r;
    vec3_t             nrm_r;
    vec3_t             mat_r;
    logic              vld_r;
    logic              tri_end_r;
    logic              last_r;
    logic              done_r;
    logic              wait_done;
    logic              handshake;
    logic              is_last_vtx;

    assign wait_done   = (wait_cnt == WAIT_LAST);
    assign handshake   = (state == EMIT) && vld_r && vf.vertex_ready_in;
    assign is_last_vtx = (vtx_cnt == count_r - 16'd1);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (vf.start_in && vf.index_count_in != '0) state_nxt = IDX_WAIT;
            IDX_WAIT:  if (wait_done) state_nxt = ATTR_WAIT;
            ATTR_WAIT: if (wait_done) state_nxt = EMIT;
            EMIT:      if (handshake) state_nxt = last_r ? IDLE : IDX_WAIT;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wait_cnt  <= '0;
            vtx_cnt   <= '0;
            count_r   <= '0;
            tri_phase <= '0;
            pos_id    <= '0;
            nrm_id    <= '0;
            mat_id    <= '0;
            pos_r     <= '0;
            nrm_r     <= '0;
            mat_r     <= '0;
            vld_r     <= 1'b0;
            tri_end_r <= 1'b0;
            last_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    // An empty walk completes immediately without fetching.
                    if (vf.start_in) begin
                        if (vf.index_count_in == '0) begin
                            done_r <= 1'b1;
                        end else begin
                            vtx_cnt   <= '0;
                            tri_phase <= '0;
                            count_r   <= vf.index_count_in;
                            wait_cnt  <= '0;
                        end
                    end
                end
                IDX_WAIT: begin
                    if (wait_done) begin
                        pos_id   <= vf.index_in[POS_SEL];
                        nrm_id   <= vf.index_in[NRM_SEL];
                        mat_id   <= vf.index_in[MAT_SEL];
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ATTR_WAIT: begin
                    if (wait_done) begin
                        pos_r     <= vf.position_in;
                        nrm_r     <= vf.normal_in;
                        mat_r     <= vf.material_in;
                        vld_r     <= 1'b1;
                        tri_end_r <= (tri_phase == 2'd2);
                        last_r    <= is_last_vtx;
                        wait_cnt  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                EMIT: begin
                    if (handshake) begin
                        vld_r     <= 1'b0;
                        tri_end_r <= 1'b0;
                        last_r    <= 1'b0;
                        if (last_r) begin
                            done_r <= 1'b1;
                        end else begin
                            vtx_cnt   <= vtx_cnt + 16'd1;
                            tri_phase <= (tri_phase == 2'd2) ? 2'd0 : tri_phase + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign vf.busy_out            = (state != IDLE);
    assign vf.done_out            = done_r;
    assign vf.index_id_out        = vtx_cnt;
    assign vf.position_id_out     = pos_id;
    assign vf.normal_id_out       = nrm_id;
    assign vf.material_id_out     = mat_id;
    assign vf.vertex_valid_out    = vld_r;
    assign vf.vertex_position_out = pos_r;
    assign vf.vertex_normal_out   = nrm_r;
    assign vf.vertex_material_out = mat_r;
    assign vf.tri_end_out         = tri_end_r;
    assign vf.last_out            = last_r;
endmodule

// File: tb/tb_vertex_fetch.sv
// Randomized bench for vertex_fetch with memory models and a walk-level
// reference model checked on every cycle.
module tb_vertex_fetch;
    import gfx_pkg::*;

    localparam int LAT     = 2;
    localparam int SPACING = 2 * LAT + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    vertex_fetch_if vf ();

    vertex_fetch #(.MEM_LATENCY(LAT)) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .vf     (vf)
    );

    int n_checks = 0;
    int n_fail   = 0;

    idx3_t idx_mem [256];

    function automatic vec3_t attr_fn(input attr_id_t a, input logic [7:0] salt);
        vec3_t v;
        for (int e = 0; e < 3; e++) v[e] = {salt, 8'(e), 4'h0, a};
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory: address seen at edge E is captured, data usable at edge E+LAT.
    always @(posedge clk) begin
        vf.index_in    <= idx_mem[vf.index_id_out[7:0]];
        vf.position_in <= attr_fn(vf.position_id_out, 8'hA1);
        vf.normal_in   <= attr_fn(vf.normal_id_out, 8'hB2);
    end
    assign vf.material_in = attr_fn(vf.material_id_out, 8'hC3);

    // Reference model state
    bit    m_busy = 0;
    bit    done_due = 0;
    int    m_n = 0, m_k = 0, m_ref = 0;
    int    cyc = 0;
    int    hs_cnt = 0, done_cnt = 0, stall_cnt = 0, tri_cnt = 0, last_cnt = 0;
    int    done_cyc = 0;
    int    hs_cyc[$];
    logic  prev_valid = 1'b0, prev_ready = 1'b0;
    vec3_t held_pos, held_nrm, held_mat;
    logic [1:0] held_flags;
    idx3_t t;

    int ready_mode = 0;
    int stall_k = 0, stall_left = 0;

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctrl"}, 128'({vf.busy_out, vf.done_out, vf.vertex_valid_out,
                                  vf.tri_end_out, vf.last_out}), 128'(0));
        chk({tag, "_addr"}, 128'({vf.index_id_out, vf.position_id_out,
                                  vf.normal_id_out, vf.material_id_out}), 128'(0));
        chk({tag, "_pos"}, 128'(vf.vertex_position_out), 128'(0));
        chk({tag, "_nrm"}, 128'(vf.vertex_normal_out), 128'(0));
        chk({tag, "_mat"}, 128'(vf.vertex_material_out), 128'(0));
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            check_all_zero("reset_state");
            m_busy = 0;
            done_due = 0;
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            chk("busy", 128'(vf.busy_out), 128'(m_busy));
            chk("done", 128'(vf.done_out), 128'(done_due));
            if (vf.done_out) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (!m_busy) chk("idle_valid", 128'(vf.vertex_valid_out), 128'(0));
            if (prev_valid && !prev_ready) begin
                chk("hold_valid", 128'(vf.vertex_valid_out), 128'(1));
                chk("hold_pos", 128'(vf.vertex_position_out), 128'(held_pos));
                chk("hold_nrm", 128'(vf.vertex_normal_out), 128'(held_nrm));
                chk("hold_mat", 128'(vf.vertex_material_out), 128'(held_mat));
                chk("hold_flags", 128'({vf.tri_end_out, vf.last_out}), 128'(held_flags));
                stall_cnt++;
            end
            if (vf.vertex_valid_out && !prev_valid)
                chk("valid_latency", 128'(cyc), 128'(m_ref + SPACING));

            done_due = 0;
            if (vf.start_in && !m_busy) begin
                if (vf.index_count_in == 16'd0) begin
                    done_due = 1;
                end else begin
                    m_busy = 1;
                    m_n = int'(vf.index_count_in);
                    m_k = 0;
                    m_ref = cyc;
                end
            end
            if (vf.vertex_valid_out && vf.vertex_ready_in && m_busy) begin
                t = idx_mem[8'(m_k)];
                chk("vtx_index_id", 128'(vf.index_id_out), 128'(m_k));
                chk("vtx_attr_ids", 128'({vf.position_id_out, vf.normal_id_out, vf.material_id_out}),
                    128'({t[0], t[1], t[2]}));
                chk("vtx_pos", 128'(vf.vertex_position_out), 128'(attr_fn(t[0], 8'hA1)));
                chk("vtx_nrm", 128'(vf.vertex_normal_out), 128'(attr_fn(t[1], 8'hB2)));
                chk("vtx_mat", 128'(vf.vertex_material_out), 128'(attr_fn(t[2], 8'hC3)));
                chk("vtx_tri_end", 128'(vf.tri_end_out), 128'((m_k % 3) == 2));
                chk("vtx_last", 128'(vf.last_out), 128'(m_k == m_n - 1));
                hs_cnt++;
                hs_cyc.push_back(cyc);
                if (vf.tri_end_out) tri_cnt++;
                if (vf.last_out) last_cnt++;
                if (m_k == m_n - 1) begin
                    m_busy = 0;
                    done_due = 1;
                end else begin
                    m_k++;
                    m_ref = cyc;
                end
            end
            prev_valid = vf.vertex_valid_out;
            prev_ready = vf.vertex_ready_in;
            held_pos   = vf.vertex_position_out;
            held_nrm   = vf.vertex_normal_out;
            held_mat   = vf.vertex_material_out;
            held_flags = {vf.tri_end_out, vf.last_out};
        end
    end

    initial begin
        vf.vertex_ready_in = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: vf.vertex_ready_in = ($urandom_range(0, 2) != 0);
                2: begin
                    if (vf.vertex_valid_out && m_k == stall_k && stall_left > 0) begin
                        vf.vertex_ready_in = 1'b0;
                        stall_left--;
                    end else begin
                        vf.vertex_ready_in = 1'b1;
                    end
                end
                default: vf.vertex_ready_in = 1'b1;
            endcase
        end
    end

    task automatic start_walk(input int n);
        @(posedge clk);
        #1;
        vf.start_in = 1'b1;
        vf.index_count_in = 16'(n);
        @(posedge clk);
        #1;
        vf.start_in = 1'b0;
        vf.index_count_in = 16'($urandom);
    endtask

    task automatic wait_walk_end(input int d0, input string tag);
        int i;
        i = 0;
        while (done_cnt == d0 && i < 400) begin
            @(posedge clk);
            i++;
        end
        chk({tag, "_timeout"}, 128'(done_cnt == d0), 128'(0));
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int h0, d0, s0, tc0, lc0, n, i, nw;
        vf.start_in = 1'b0;
        vf.index_count_in = '0;
        for (int a = 0; a < 256; a++)
            idx_mem[a] = {12'($urandom), 12'($urandom), 12'($urandom)};

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("after_reset_idle", 128'({vf.busy_out, vf.vertex_valid_out, vf.done_out}), 128'(0));

        // Three vertices, ready high
        h0 = hs_cnt; d0 = done_cnt; tc0 = tri_cnt; lc0 = last_cnt;
        start_walk(3);
        wait_walk_end(d0, "t034");
        chk("t034_vertices", 128'(hs_cnt - h0), 128'(3));
        chk("t034_dones", 128'(done_cnt - d0), 128'(1));
        chk("t034_tri_end", 128'(tri_cnt - tc0), 128'(1));
        chk("t034_last", 128'(last_cnt - lc0), 128'(1));
        n = hs_cyc.size();
        chk("t034_spacing_a", 128'(hs_cyc[n-1] - hs_cyc[n-2]), 128'(5));
        chk("t034_spacing_b", 128'(hs_cyc[n-2] - hs_cyc[n-3]), 128'(5));
        chk("t034_done_delay", 128'(done_cyc - hs_cyc[n-1]), 128'(1));

        // Index triple {7,5,3}
        idx_mem[0] = {12'd7, 12'd5, 12'd3};
        d0 = done_cnt;
        start_walk(1);
        i = 0;
        while (!vf.vertex_valid_out && i < 30) begin
            @(negedge clk);
            i++;
        end
        chk("t039_valid_seen", 128'(vf.vertex_valid_out), 128'(1));
        chk("t039_position_id", 128'(vf.position_id_out), 128'(3));
        chk("t039_normal_id", 128'(vf.normal_id_out), 128'(5));
        chk("t039_material_id", 128'(vf.material_id_out), 128'(7));
        chk("t039_pos0", 128'(vf.vertex_position_out[0]), 128'(32'hA100_0003));
        chk("t039_nrm2", 128'(vf.vertex_normal_out[2]), 128'(32'hB202_0005));
        chk("t039_mat1", 128'(vf.vertex_material_out[1]), 128'(32'hC301_0007));
        wait_walk_end(d0, "t039");

        // Four vertices, vertex 2 stalled 10 cycles
        h0 = hs_cnt; d0 = done_cnt; s0 = stall_cnt; tc0 = tri_cnt; lc0 = last_cnt;
        stall_k = 1; stall_left = 10; ready_mode = 2;
        start_walk(4);
        wait_walk_end(d0, "t035");
        ready_mode = 0;
        chk("t035_vertices", 128'(hs_cnt - h0), 128'(4));
        chk("t035_stall_cycles", 128'(stall_cnt - s0), 128'(10));
        chk("t035_tri_end", 128'(tri_cnt - tc0), 128'(1));
        chk("t035_last", 128'(last_cnt - lc0), 128'(1));

        // Empty walk
        h0 = hs_cnt; d0 = done_cnt;
        start_walk(0);
        wait_walk_end(d0, "t036");
        chk("t036_vertices", 128'(hs_cnt - h0), 128'(0));
        chk("t036_dones", 128'(done_cnt - d0), 128'(1));

        // Start pulse in the middle of a walk is ignored
        h0 = hs_cnt; d0 = done_cnt;
        start_walk(6);
        repeat (8) @(posedge clk);
        #1;
        vf.start_in = 1'b1;
        vf.index_count_in = 16'd2;
        @(posedge clk);
        #1;
        vf.start_in = 1'b0;
        wait_walk_end(d0, "t037");
        repeat (20) @(posedge clk);
        chk("t037_vertices", 128'(hs_cnt - h0), 128'(6));
        chk("t037_dones", 128'(done_cnt - d0), 128'(1));

        // Reset during the attribute wait of vertex 2
        h0 = hs_cnt; d0 = done_cnt;
        start_walk(5);
        i = 0;
        while (hs_cnt == h0 && i < 40) begin
            @(posedge clk);
            i++;
        end
        chk("t038_first_vertex", 128'(hs_cnt - h0), 128'(1));
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_all_zero("t038_async");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        chk("t038_no_done", 128'(done_cnt - d0), 128'(0));
        h0 = hs_cnt; d0 = done_cnt;
        start_walk(1);
        wait_walk_end(d0, "t038_restart");
        chk("t038_restart_vertices", 128'(hs_cnt - h0), 128'(1));

        // Random walks with random backpressure
        ready_mode = 1;
        for (int w = 0; w < 8; w++) begin
            nw = $urandom_range(1, 12);
            h0 = hs_cnt; d0 = done_cnt;
            start_walk(nw);
            wait_walk_end(d0, "rand_walk");
            chk("rand_vertices", 128'(hs_cnt - h0), 128'(nw));
            chk("rand_dones", 128'(done_cnt - d0), 128'(1));
        end
        ready_mode = 0;
        repeat (5) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
